// File: rtl/acorn_word_engine.sv
// acorn_word_engine: ACORN-128 state update unrolled W steps per word, with keystream.
// Define ACORN_STEP_CNT_EN to build the 64-bit step counter; otherwise step_cnt is tied to 0.
module acorn_word_engine #(
    parameter int W       = 8,
    parameter int STATE_W = 293
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [STATE_W-1:0] state_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               ca_in,
    input  logic               cb_in,
    input  logic               decrypt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [W-1:0]       out_ks,
    output logic [STATE_W-1:0] state_out,
    output logic [63:0]        step_cnt
);

    if (W != 1 && W != 8 && W != 16 && W != 32) begin : g_bad_w
        $error("acorn_word_engine: W must be 1, 8, 16 or 32");
    end

    if (STATE_W != 293) begin : g_bad_state_w
        $error("acorn_word_engine: STATE_W must be 293");
    end

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    logic [STATE_W-1:0] state_q;
    logic               out_valid_q;
    logic [W-1:0]       out_data_q;
    logic [W-1:0]       out_ks_q;

    logic [STATE_W-1:0] nxt_state;
    logic [W-1:0]       nxt_data;
    logic [W-1:0]       nxt_ks;
    logic               ks_b;
    logic               f_b;
    logic               m_b;
    logic               accept;

    // Load wins over a word offered in the same cycle, so the word stays with the producer.
    assign in_ready = ~load_valid & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        nxt_state = state_q;
        nxt_data  = '0;
        nxt_ks    = '0;
        ks_b      = 1'b0;
        f_b       = 1'b0;
        m_b       = 1'b0;
        for (int j = 0; j < W; j++) begin
            // Taps run high to low so each reads its sources before they change.
            nxt_state[289] = nxt_state[289] ^ nxt_state[235] ^ nxt_state[230];
            nxt_state[230] = nxt_state[230] ^ nxt_state[196] ^ nxt_state[193];
            nxt_state[193] = nxt_state[193] ^ nxt_state[160] ^ nxt_state[154];
            nxt_state[154] = nxt_state[154] ^ nxt_state[111] ^ nxt_state[107];
            nxt_state[107] = nxt_state[107] ^ nxt_state[66] ^ nxt_state[61];
            nxt_state[61]  = nxt_state[61] ^ nxt_state[23] ^ nxt_state[0];

            ks_b = nxt_state[12] ^ nxt_state[154]
                 ^ maj(nxt_state[235], nxt_state[61], nxt_state[193])
                 ^ ch(nxt_state[230], nxt_state[111], nxt_state[66]);

            f_b = nxt_state[0] ^ ~nxt_state[107]
                ^ maj(nxt_state[244], nxt_state[23], nxt_state[160])
                ^ (ca_in & nxt_state[196])
                ^ (cb_in & ks_b);

            // The state always absorbs plaintext, whichever direction we run.
            m_b = in_data[j] ^ (decrypt & ks_b);

            nxt_data[j] = in_data[j] ^ ks_b;
            nxt_ks[j]   = ks_b;
            nxt_state   = {f_b ^ m_b, nxt_state[STATE_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ks_q    <= '0;
        end else if (load_valid) begin
            state_q     <= state_in;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= nxt_state;
            out_valid_q <= 1'b1;
            out_data_q  <= nxt_data;
            out_ks_q    <= nxt_ks;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ACORN_STEP_CNT_EN
    logic [63:0] step_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_cnt_q <= '0;
        end else if (load_valid) begin
            step_cnt_q <= '0;
        end else if (accept) begin
            step_cnt_q <= step_cnt_q + 64'(W);
        end
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ks    = out_ks_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_acorn_word_engine.sv
// tb_acorn_word_engine: directed and model-based checks of acorn_word_engine.
// Three instances (W=1, 8, 32) share control inputs and run in lockstep.
module tb_acorn_word_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [292:0] state_in;
    logic         in_valid;
    logic         ca;
    logic         cb;
    logic         decrypt;
    logic         out_ready;

    logic [0:0]   d1;
    logic [7:0]   d8;
    logic [31:0]  d32;

    logic         rdy1, rdy8, rdy32;
    logic         ov1, ov8, ov32;
    logic [0:0]   od1, ok1;
    logic [7:0]   od8, ok8;
    logic [31:0]  od32, ok32;
    logic [292:0] so1, so8, so32;
    logic [63:0]  sc1, sc8, sc32;

    int nvec = 0;
    int nerr = 0;

    logic [292:0] m1, m8, m32;
    logic [292:0] s0, e1, e8, e32, ex;
    logic [31:0]  eo, ek;
    logic [31:0]  pt [64];
    logic [31:0]  c1 [64];
    logic [31:0]  c8 [64];
    logic [31:0]  c32 [64];
    logic [31:0]  k1 [64];
    logic [31:0]  k8 [64];
    logic [31:0]  k32 [64];
    logic         cav [64];
    logic         cbv [64];

    always #5 clk = ~clk;

    acorn_word_engine #(.W(1), .STATE_W(293)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .state_in(state_in),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(d1), .ca_in(ca),
        .cb_in(cb), .decrypt(decrypt), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ks(ok1), .state_out(so1), .step_cnt(sc1)
    );

    acorn_word_engine #(.W(8), .STATE_W(293)) u8 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .state_in(state_in),
        .in_valid(in_valid), .in_ready(rdy8), .in_data(d8), .ca_in(ca),
        .cb_in(cb), .decrypt(decrypt), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .out_ks(ok8), .state_out(so8), .step_cnt(sc8)
    );

    acorn_word_engine #(.W(32), .STATE_W(293)) u32 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .state_in(state_in),
        .in_valid(in_valid), .in_ready(rdy32), .in_data(d32), .ca_in(ca),
        .cb_in(cb), .decrypt(decrypt), .out_valid(ov32), .out_ready(out_ready),
        .out_data(od32), .out_ks(ok32), .state_out(so32), .step_cnt(sc32)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [292:0] s);
        load_valid = 1'b1;
        state_in   = s;
        in_valid   = 1'b0;
        tick();
        load_valid = 1'b0;
    endtask

    // Bit-serial reference written straight from the step equations.
    task automatic model_word(input int w, inout logic [292:0] s,
                              input logic [31:0] d, input logic ca_b,
                              input logic cb_b, input logic dec,
                              output logic [31:0] o, output logic [31:0] k);
        logic [292:0] t;
        logic kb, fb, mb, mj1, mj2, chv;
        o = '0;
        k = '0;
        for (int j = 0; j < w; j++) begin
            t = s;
            t[289] = t[289] ^ t[235] ^ t[230];
            t[230] = t[230] ^ t[196] ^ t[193];
            t[193] = t[193] ^ t[160] ^ t[154];
            t[154] = t[154] ^ t[111] ^ t[107];
            t[107] = t[107] ^ t[66] ^ t[61];
            t[61]  = t[61] ^ t[23] ^ t[0];
            mj1 = (t[235] & t[61]) | (t[235] & t[193]) | (t[61] & t[193]);
            chv = t[230] ? t[111] : t[66];
            kb  = t[12] ^ t[154] ^ mj1 ^ chv;
            mj2 = (t[244] & t[23]) | (t[244] & t[160]) | (t[23] & t[160]);
            fb  = t[0] ^ ~t[107] ^ mj2 ^ (ca_b & t[196]) ^ (cb_b & kb);
            mb  = dec ? (d[j] ^ kb) : d[j];
            o[j] = d[j] ^ kb;
            k[j] = kb;
            s = {fb ^ mb, t[292:1]};
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        load_valid = 1'b0; state_in = '0; in_valid = 1'b0;
        ca = 1'b0; cb = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
        d1 = '0; d8 = '0; d32 = '0;
        tick();
        tick();
        nvec++;
        if ({ov1, ov8, ov32} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_valid got %b want 000", {ov1, ov8, ov32});
        end
        nvec++;
        if (so1 !== '0 || so8 !== '0 || so32 !== '0) begin
            nerr++;
            $display("FAIL reset_state got %h want 0", so8);
        end
        nvec++;
        if (od8 !== 8'h00 || ok8 !== 8'h00 || od32 !== 32'h0 || sc32 !== 64'h0) begin
            nerr++;
            $display("FAIL reset_out got %h/%h/%h/%h want 0", od8, ok8, od32, sc32);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_encrypt_zero;
        do_load('0);
        decrypt = 1'b0; ca = 1'b0; cb = 1'b0; out_ready = 1'b1;
        d1 = '0; d8 = 8'h00; d32 = '0;
        in_valid = 1'b1;
        #1;
        nvec++;
        if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin
            nerr++;
            $display("FAIL enc0_pre got v=%b r=%b want v=0 r=1", ov8, rdy8);
        end
        tick();
        in_valid = 1'b0;
        ex = '0;
        ex[292:285] = 8'hFF;
        nvec++;
        if (ov8 !== 1'b1 || od8 !== 8'h00 || ok8 !== 8'h00) begin
            nerr++;
            $display("FAIL enc0_out got v=%b d=%h k=%h want 1/00/00", ov8, od8, ok8);
        end
        nvec++;
        if (so8 !== ex) begin
            nerr++;
            $display("FAIL enc0_state got %h want %h", so8, ex);
        end
        tick();
        nvec++;
        if (ov8 !== 1'b0) begin
            nerr++;
            $display("FAIL enc0_drain got %b want 0", ov8);
        end
    endtask

    task automatic test_decrypt_a5;
        do_load('0);
        decrypt = 1'b1; ca = 1'b0; cb = 1'b0;
        d8 = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ex = '0;
        ex[292:285] = 8'h5A;
        nvec++;
        if (od8 !== 8'hA5 || ok8 !== 8'h00) begin
            nerr++;
            $display("FAIL deca5_out got d=%h k=%h want A5/00", od8, ok8);
        end
        nvec++;
        if (so8 !== ex) begin
            nerr++;
            $display("FAIL deca5_state got %h want %h", so8, ex);
        end
        tick();
    endtask

    task automatic test_hand_vectors;
        // S0=1: the S61 tap fires, then the bit drifts to 53.
        ex = '0; ex[0] = 1'b1;
        do_load(ex);
        decrypt = 1'b0; ca = 1'b0; cb = 1'b0; d8 = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ex = '0; ex[292:285] = 8'hFE; ex[53] = 1'b1;
        nvec++;
        if (so8 !== ex || ok8 !== 8'h00) begin
            nerr++;
            $display("FAIL hv_s0_state got %h k=%h want %h", so8, ok8, ex);
        end
        // S12=1 with cb=1: keystream bit 0 set and fed into f.
        ex = '0; ex[12] = 1'b1;
        do_load(ex);
        cb = 1'b1; d8 = 8'h03;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ex = '0; ex[292:285] = 8'hFD; ex[4] = 1'b1;
        nvec++;
        if (ok8 !== 8'h01 || od8 !== 8'h02) begin
            nerr++;
            $display("FAIL hv_s12_out got d=%h k=%h want 02/01", od8, ok8);
        end
        nvec++;
        if (so8 !== ex) begin
            nerr++;
            $display("FAIL hv_s12_state got %h want %h", so8, ex);
        end
        // Decrypt with keystream: absorbed bit is plaintext, not ciphertext.
        ex = '0; ex[12] = 1'b1;
        do_load(ex);
        cb = 1'b0; decrypt = 1'b1; d8 = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ex = '0; ex[292:285] = 8'hFF; ex[4] = 1'b1;
        nvec++;
        if (od8 !== 8'h00 || ok8 !== 8'h01 || so8 !== ex) begin
            nerr++;
            $display("FAIL hv_dec_ks got d=%h k=%h s=%h want 00/01/%h", od8, ok8, so8, ex);
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        do_load('0);
        m8 = '0;
        decrypt = 1'b0; ca = 1'b1; cb = 1'b0;
        d8 = 8'h3C; out_ready = 1'b0; in_valid = 1'b1;
        model_word(8, m8, 32'h3C, 1'b1, 1'b0, 1'b0, eo, ek);
        tick();
        nvec++;
        if (ov8 !== 1'b1 || od8 !== eo[7:0] || ok8 !== ek[7:0] || so8 !== m8) begin
            nerr++;
            $display("FAIL bp_first got d=%h k=%h want %h/%h", od8, ok8, eo[7:0], ek[7:0]);
        end
        d8 = words[0];
        for (int c = 0; c < 3; c++) begin
            nvec++;
            if (rdy8 !== 1'b0 || rdy32 !== 1'b0) begin
                nerr++;
                $display("FAIL bp_ready cyc%0d got %b want 0", c, rdy8);
            end
            tick();
            nvec++;
            if (ov8 !== 1'b1 || od8 !== eo[7:0] || ok8 !== ek[7:0] || so8 !== m8) begin
                nerr++;
                $display("FAIL bp_hold cyc%0d got d=%h k=%h want %h/%h",
                         c, od8, ok8, eo[7:0], ek[7:0]);
            end
        end
        out_ready = 1'b1;
        #1;
        nvec++;
        if (rdy8 !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release got %b want 1", rdy8);
        end
        for (int c = 0; c < 3; c++) begin
            d8 = words[c];
            model_word(8, m8, {24'h0, words[c]}, 1'b1, 1'b0, 1'b0, eo, ek);
            tick();
            nvec++;
            if (ov8 !== 1'b1 || od8 !== eo[7:0] || so8 !== m8) begin
                nerr++;
                $display("FAIL bp_stream w%0d got v=%b d=%h want 1/%h", c, ov8, od8, eo[7:0]);
            end
        end
        in_valid = 1'b0;
        ca = 1'b0;
        tick();
    endtask

    task automatic test_roundtrip;
        for (int k = 0; k < 9; k++) s0[k*32 +: 32] = $urandom;
        s0[292:288] = 5'($urandom);
        for (int i = 0; i < 64; i++) begin
            pt[i]  = $urandom;
            cav[i] = 1'($urandom);
            cbv[i] = 1'($urandom);
        end
        do_load(s0);
        m1 = s0; m8 = s0; m32 = s0;
        out_ready = 1'b1; decrypt = 1'b0;
        for (int i = 0; i < 64; i++) begin
            d1 = pt[i][0]; d8 = pt[i][7:0]; d32 = pt[i];
            ca = cav[i]; cb = cbv[i]; in_valid = 1'b1;
            model_word(1, m1, pt[i], cav[i], cbv[i], 1'b0, eo, ek);
            c1[i] = eo; k1[i] = ek;
            model_word(8, m8, pt[i], cav[i], cbv[i], 1'b0, eo, ek);
            c8[i] = eo; k8[i] = ek;
            model_word(32, m32, pt[i], cav[i], cbv[i], 1'b0, eo, ek);
            c32[i] = eo; k32[i] = ek;
            tick();
            nvec++;
            if (od1 !== c1[i][0:0] || ok1 !== k1[i][0:0]) begin
                nerr++;
                $display("FAIL rt_enc_w1 #%0d got %b/%b want %b/%b",
                         i, od1, ok1, c1[i][0], k1[i][0]);
            end
            nvec++;
            if (od8 !== c8[i][7:0] || ok8 !== k8[i][7:0]) begin
                nerr++;
                $display("FAIL rt_enc_w8 #%0d got %h/%h want %h/%h",
                         i, od8, ok8, c8[i][7:0], k8[i][7:0]);
            end
            nvec++;
            if (od32 !== c32[i] || ok32 !== k32[i]) begin
                nerr++;
                $display("FAIL rt_enc_w32 #%0d got %h/%h want %h/%h",
                         i, od32, ok32, c32[i], k32[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        e1 = m1; e8 = m8; e32 = m32;
        nvec++;
        if (so1 !== e1 || so8 !== e8 || so32 !== e32) begin
            nerr++;
            $display("FAIL rt_enc_state got %h want %h", so8, e8);
        end
        do_load(s0);
        decrypt = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d1 = c1[i][0:0]; d8 = c8[i][7:0]; d32 = c32[i];
            ca = cav[i]; cb = cbv[i]; in_valid = 1'b1;
            tick();
            nvec++;
            if (od1 !== pt[i][0:0] || ok1 !== k1[i][0:0]) begin
                nerr++;
                $display("FAIL rt_dec_w1 #%0d got %b want %b", i, od1, pt[i][0]);
            end
            nvec++;
            if (od8 !== pt[i][7:0] || ok8 !== k8[i][7:0]) begin
                nerr++;
                $display("FAIL rt_dec_w8 #%0d got %h want %h", i, od8, pt[i][7:0]);
            end
            nvec++;
            if (od32 !== pt[i] || ok32 !== k32[i]) begin
                nerr++;
                $display("FAIL rt_dec_w32 #%0d got %h want %h", i, od32, pt[i]);
            end
        end
        in_valid = 1'b0;
        decrypt = 1'b0; ca = 1'b0; cb = 1'b0;
        tick();
        nvec++;
        if (so1 !== e1 || so8 !== e8 || so32 !== e32) begin
            nerr++;
            $display("FAIL rt_dec_state got %h want %h", so32, e32);
        end
    endtask

    task automatic test_load_priority;
        out_ready = 1'b1;
        d8 = 8'h00; in_valid = 1'b1;
        tick();
        ex = ~s0;
        d8 = 8'hFF; d32 = 32'hFFFF_FFFF;
        load_valid = 1'b1; state_in = ex;
        #1;
        nvec++;
        if (rdy1 !== 1'b0 || rdy8 !== 1'b0 || rdy32 !== 1'b0) begin
            nerr++;
            $display("FAIL lp_ready got %b%b%b want 000", rdy1, rdy8, rdy32);
        end
        tick();
        nvec++;
        if (so8 !== ex || so32 !== ex || ov8 !== 1'b0 || ov32 !== 1'b0) begin
            nerr++;
            $display("FAIL lp_load got v=%b s=%h want 0/%h", ov8, so8, ex);
        end
        load_valid = 1'b0; in_valid = 1'b0;
        tick();
        nvec++;
        if (so8 !== ex || ov8 !== 1'b0) begin
            nerr++;
            $display("FAIL lp_noconsume got v=%b s=%h want 0/%h", ov8, so8, ex);
        end
    endtask

    task automatic test_reset_midstream;
        do_load(s0);
        out_ready = 1'b1; in_valid = 1'b1;
        d1 = 1'b1; d8 = 8'h5B; d32 = 32'hDEAD_BEEF;
        tick();
        tick();
        rst = 1'b0;
        tick();
        nvec++;
        if ({ov1, ov8, ov32} !== 3'b000 || so1 !== '0 || so8 !== '0 || so32 !== '0) begin
            nerr++;
            $display("FAIL midrst_state got v=%b s=%h want 000/0", {ov1, ov8, ov32}, so8);
        end
        nvec++;
        if (od8 !== 8'h0 || ok8 !== 8'h0 || od32 !== 32'h0 || ok32 !== 32'h0
            || sc8 !== 64'h0 || sc32 !== 64'h0) begin
            nerr++;
            $display("FAIL midrst_out got %h/%h/%h want 0", od8, ok8, sc32);
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_step_cnt;
        do_load('0);
        nvec++;
        if (sc1 !== 64'h0 || sc8 !== 64'h0 || sc32 !== 64'h0) begin
            nerr++;
            $display("FAIL cnt_load got %h want 0", sc32);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        tick();
`ifdef ACORN_STEP_CNT_EN
        nvec++;
        if (sc1 !== 64'd5 || sc8 !== 64'd40 || sc32 !== 64'd160) begin
            nerr++;
            $display("FAIL cnt_five got %0d/%0d/%0d want 5/40/160", sc1, sc8, sc32);
        end
        force u32.step_cnt_q = 64'hFFFF_FFFF_FFFF_FFF0;
        #1;
        release u32.step_cnt_q;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (sc32 !== 64'h10) begin
            nerr++;
            $display("FAIL cnt_wrap got %h want 10", sc32);
        end
        do_load('0);
        nvec++;
        if (sc32 !== 64'h0) begin
            nerr++;
            $display("FAIL cnt_clear got %h want 0", sc32);
        end
`else
        nvec++;
        if (sc1 !== 64'h0 || sc8 !== 64'h0 || sc32 !== 64'h0) begin
            nerr++;
            $display("FAIL cnt_tied got %h want 0", sc32);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_encrypt_zero();
        test_decrypt_a5();
        test_hand_vectors();
        test_backpressure();
        test_roundtrip();
        test_load_priority();
        test_reset_midstream();
        test_step_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/acorn_word_engine.md
Name: acorn_word_engine

Overview:
- Parametrised successor to the single-step ACORN-128 state update.
- Advances the 293-bit ACORN state by W steps per accepted word, unrolled combinationally, and registers the result.
- Generates W keystream bits per word, with encrypt and decrypt modes and valid/ready handshakes on both sides.
- Sits between the init/AD/finalise sequencer, which loads the state and drives ca/cb, and the data datapath.

Parameters:
- W, default 8: steps (bits) per word. Legal values are 1, 8, 16 and 32; any other value triggers an elaboration error.
- STATE_W, default 293: ACORN-128 state width. Fixed; exposed for port sizing only.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-low reset.
- load_valid, input, 1: load state_in into the state register.
- state_in, input, STATE_W: state to load.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: engine can accept a word.
- in_data, input, W: message word (encrypt) or ciphertext word (decrypt).
- ca_in, input, 1: ca control bit, held for all W steps of the word.
- cb_in, input, 1: cb control bit, held for all W steps of the word.
- decrypt, input, 1: 0 = encrypt, 1 = decrypt. Sampled with the word.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: consumer accepts the output word.
- out_data, output, W: ciphertext (encrypt) or plaintext (decrypt).
- out_ks, output, W: keystream bits used for the word.
- state_out, output, STATE_W: current state register.
- step_cnt, output, 64: steps performed since the last load (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clk edge): state=0, out_valid=0, out_data=0, out_ks=0, step_cnt=0. Reset aborts any word in flight.
- Single step j, applied to state S:
  - LFSR taps, applied first:
    - S289 ^= S235 ^ S230
    - S230 ^= S196 ^ S193
    - S193 ^= S160 ^ S154
    - S154 ^= S111 ^ S107
    - S107 ^= S66 ^ S61
    - S61 ^= S23 ^ S0
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66), computed on the post-tap state.
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca & S196) ^ (cb & ks).
  - Message bit: m = in_data[j] in encrypt mode; m = in_data[j] ^ ks in decrypt mode.
  - out_data[j] = in_data[j] ^ ks. out_ks[j] = ks.
  - Shift: S = {f ^ m, S[292:1]}.
- Bit ordering: LSB first. Step j processes in_data[j].
- Handshake and timing:
  - A word is accepted when in_valid & in_ready.
  - State, out_data, out_ks and out_valid=1 update on the same clk edge. Latency is 1 cycle.
  - in_ready = ~out_valid | out_ready. This is a one-entry output buffer and sustains full throughput.
  - When out_valid=1 and out_ready=0, in_ready=0 and the state and outputs hold stable.
  - out_valid clears when out_ready=1 and no new word is accepted in that cycle.
- Load:
  - load_valid=1 overwrites state with state_in, clears out_valid and clears step_cnt.
  - Load has priority over a simultaneous word accept. That word is not consumed: in_ready=0 while load_valid=1.
- state_out always reflects the state register.

Optional Feature:
- Macro: ACORN_STEP_CNT_EN.
- Defined: step_cnt increments by W on each accepted word and wraps modulo 2^64.
- Undefined: the step_cnt port is tied to 0 and no counter logic is built.

Test Plan:
- W=8, load state=0, encrypt, ca=cb=0, in_data=0x00 -> out_ks=0x00, out_data=0x00, state_out[292:285]=0xFF, all other state bits 0, out_valid=1 one cycle after accept.
- W=8, load state=0, decrypt, ca=cb=0, in_data=0xA5 -> out_data=0xA5, out_ks=0x00, state_out[292:285]=0x5A.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and state, out_data, out_ks frozen. Releasing out_ready gives one word per cycle thereafter.
- Encrypt 64 random words then decrypt the ciphertext from the same loaded state -> plaintext recovered bit-exactly and final state_out identical in both runs. Run for W=1, 8 and 32, and match a bit-serial software model.
- Simultaneous load_valid and in_valid -> state=state_in, word not consumed, out_valid=0. Reset asserted mid-stream -> all outputs 0 on the next edge.
- With ACORN_STEP_CNT_EN, W=32, 5 words accepted -> step_cnt=160. Preload a counter value near 2^64 via a force and check wrap-around. Without the macro -> step_cnt=0.
